wb_scheduler: RTL and testbench
===============================

WB_SCHEDULER -- requirements
Module: wb_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-002 SHALL have parameter REG_ADDR_WIDTH, default 5, register index width (32 registers).
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports ex_valid in 1, ex_rd in REG_ADDR_WIDTH, ex_data in DATA_WIDTH, ex_ready out 1: execute-unit writeback request.
REQ-006 SHALL have ports ld_valid in 1, ld_rd in REG_ADDR_WIDTH, ld_data in DATA_WIDTH, ld_ready out 1: load-unit writeback request.
REQ-007 SHALL have ports rf_we out 1, rf_rd_addr out REG_ADDR_WIDTH, rf_rd_data out DATA_WIDTH: register-file write port.
REQ-008 SHALL have ports iss_valid in 1, iss_rd in REG_ADDR_WIDTH, iss_ready out 1: issue-side destination reservation.
REQ-009 SHALL have ports rs1_addr, rs2_addr in REG_ADDR_WIDTH; rs1_busy, rs2_busy out 1: hazard query.
REQ-010 SHALL have ports flush in 1 (pipeline flush) and err_underflow out 1 (sticky error).

Function
REQ-011 Transfer occurs in a cycle where valid and ready are both high; a requester SHALL hold valid, rd and data stable until ready.
REQ-012 ready SHALL be combinational; at most one of ex_ready/ld_ready SHALL be high per cycle.
REQ-013 One valid requester SHALL be granted immediately; with both valid, the requester not granted last SHALL win (round-robin).
REQ-014 last_grant SHALL update only on a transfer and SHALL reset to LD, so EX wins the first tie.
REQ-015 An accepted transfer in cycle N SHALL drive rf_we=1 with its rd and data in cycle N+1; output registers SHALL be the only write-port path.
REQ-016 A transfer with rd=0 SHALL be accepted but SHALL give rf_we=0 in N+1 and SHALL not change the scoreboard.
REQ-017 With no transfer in cycle N, rf_we SHALL be 0 in N+1; rf_rd_addr and rf_rd_data SHALL hold their last values.
REQ-018 Scoreboard: a 2-bit counter per register 1..31; register 0 SHALL have no counter and SHALL never read busy.
REQ-019 iss_valid && iss_ready SHALL increment count[iss_rd] (iss_rd != 0) at the cycle end.
REQ-020 iss_ready SHALL be 0 when count[iss_rd]==3 (saturation stall), else 1; iss_rd=0 SHALL always be ready.
REQ-021 A writeback transfer to rd != 0 SHALL decrement count[rd] at the end of the transfer cycle.
REQ-022 Increment and decrement of the same register in the same cycle SHALL leave count unchanged.
REQ-023 Decrement of a zero count SHALL leave it 0 and SHALL set err_underflow, which stays 1 until reset.
REQ-024 rsX_busy SHALL be combinational: (count[rsX_addr] != 0).
REQ-025 flush=1 SHALL zero all counters at the cycle end, overriding same-cycle increment/decrement and never raising err_underflow.
REQ-026 Under flush, arbitration and the output stage SHALL be unaffected; a write already accepted SHALL still appear on rf_we.

Reset
REQ-027 Asynchronous assertion of rst_n=0 SHALL immediately force rf_we=0, rf_rd_addr=0, rf_rd_data=0, all counters 0, last_grant=LD, err_underflow=0.
REQ-028 During reset ex_ready, ld_ready, rs1_busy and rs2_busy SHALL be 0 and iss_ready SHALL be 1.
REQ-029 Reset mid-transfer SHALL discard the pending output write; no rf_we pulse SHALL follow deassertion.

Verification
REQ-030 Single write: iss rd=5; then ex_valid rd=5 data=0xDEADBEEF -> ex_ready same cycle; next cycle rf_we=1, addr=5, data=0xDEADBEEF; rs1_addr=5 busy 1 before the transfer and 0 after.
REQ-031 Contention: ex and ld both valid for 4 cycles from reset -> grants EX,LD,EX,LD; rf_we high in 4 consecutive cycles with matching addr/data.
REQ-032 Saturation: 3 issues to rd=7 -> iss_ready=0 for rd=7; one ld writeback rd=7 -> iss_ready=1 next cycle, busy stays 1 until 2 more writebacks.
REQ-033 Simultaneous events: issue rd=9 and writeback rd=9 in the same cycle with count=1 -> count stays 1, busy stays 1, err_underflow=0.
REQ-034 Flush/underflow: flush with counts nonzero -> all busy 0 next cycle; a later writeback rd=3 -> rf_we=1 and err_underflow=1 sticky.
REQ-035 Reset mid-op: rst_n low in the cycle after a transfer -> rf_we=0 immediately, busy all 0, no write after release.

Source files
------------

// File: rtl/wb_scheduler.sv
// Writeback scheduler: round-robin arbitration of execute/load writebacks onto a
// single register-file write port, plus a per-register pending-write scoreboard.
module wb_scheduler #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ex_valid,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic [DATA_WIDTH-1:0]     ex_data,
  output logic                      ex_ready,
  input  logic                      ld_valid,
  input  logic [REG_ADDR_WIDTH-1:0] ld_rd,
  input  logic [DATA_WIDTH-1:0]     ld_data,
  output logic                      ld_ready,
  output logic                      rf_we,
  output logic [REG_ADDR_WIDTH-1:0] rf_rd_addr,
  output logic [DATA_WIDTH-1:0]     rf_rd_data,
  input  logic                      iss_valid,
  input  logic [REG_ADDR_WIDTH-1:0] iss_rd,
  output logic                      iss_ready,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  output logic                      rs1_busy,
  output logic                      rs2_busy,
  input  logic                      flush,
  output logic                      err_underflow
);

  localparam int   NUM_REGS = 1 << REG_ADDR_WIDTH;
  localparam logic GRANT_EX = 1'b0;
  localparam logic GRANT_LD = 1'b1;
  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_ADDR = {REG_ADDR_WIDTH{1'b0}};

  logic                      last_grant_q, last_grant_d;
  logic                      grant_ex_s, grant_ld_s, xfer_s;
  logic [REG_ADDR_WIDTH-1:0] wb_rd_s;
  logic [DATA_WIDTH-1:0]     wb_data_s;
  logic [1:0]                count_q [NUM_REGS];
  logic [1:0]                count_d [NUM_REGS];
  logic [NUM_REGS-1:0]       inc_s, dec_s;
  logic                      err_q, err_d;
  logic                      rf_we_q, rf_we_d;
  logic [REG_ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_WIDTH-1:0]     rf_data_q, rf_data_d;

  // Round-robin arbitration: on a tie the requester not granted last wins.
  always_comb begin
    grant_ex_s = 1'b0;
    grant_ld_s = 1'b0;
    if (ex_valid && ld_valid) begin
      grant_ex_s = (last_grant_q == GRANT_LD);
      grant_ld_s = (last_grant_q == GRANT_EX);
    end else begin
      grant_ex_s = ex_valid;
      grant_ld_s = ld_valid;
    end
  end

  // Readies are suppressed while reset is asserted so nothing is accepted then.
  assign ex_ready = grant_ex_s & rst_n;
  assign ld_ready = grant_ld_s & rst_n;
  assign xfer_s   = ex_ready | ld_ready;

  // Winning request payload and round-robin pointer update.
  always_comb begin
    wb_rd_s      = ld_rd;
    wb_data_s    = ld_data;
    last_grant_d = last_grant_q;
    if (grant_ex_s) begin
      wb_rd_s   = ex_rd;
      wb_data_s = ex_data;
    end else begin
      wb_rd_s   = ld_rd;
      wb_data_s = ld_data;
    end
    if (xfer_s) begin
      last_grant_d = grant_ld_s ? GRANT_LD : GRANT_EX;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  assign iss_ready = (iss_rd == ZERO_ADDR) || (count_q[iss_rd] != 2'd3);
  assign rs1_busy  = (rs1_addr != ZERO_ADDR) && (count_q[rs1_addr] != 2'd0);
  assign rs2_busy  = (rs2_addr != ZERO_ADDR) && (count_q[rs2_addr] != 2'd0);

  // One-hot increment/decrement requests; register 0 never tracks anything.
  always_comb begin
    inc_s = {NUM_REGS{1'b0}};
    dec_s = {NUM_REGS{1'b0}};
    if (iss_valid && iss_ready && (iss_rd != ZERO_ADDR)) begin
      inc_s[iss_rd] = 1'b1;
    end else begin
      inc_s = {NUM_REGS{1'b0}};
    end
    if (xfer_s && (wb_rd_s != ZERO_ADDR)) begin
      dec_s[wb_rd_s] = 1'b1;
    end else begin
      dec_s = {NUM_REGS{1'b0}};
    end
  end

  // Counter next state; flush wins over everything and never flags underflow.
  always_comb begin
    err_d = err_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      count_d[i] = count_q[i];
      if (flush || (i == 0)) begin
        count_d[i] = 2'd0;
      end else if (inc_s[i] && !dec_s[i]) begin
        count_d[i] = count_q[i] + 2'd1;
      end else if (dec_s[i] && !inc_s[i]) begin
        if (count_q[i] == 2'd0) begin
          err_d = 1'b1;
        end else begin
          count_d[i] = count_q[i] - 2'd1;
        end
      end else begin
        count_d[i] = count_q[i];
      end
    end
  end

  // Output stage: a transfer this cycle becomes the write-port value next cycle.
  always_comb begin
    rf_we_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    if (xfer_s) begin
      rf_we_d   = (wb_rd_s != ZERO_ADDR);
      rf_addr_d = wb_rd_s;
      rf_data_d = wb_data_s;
    end else begin
      rf_we_d   = 1'b0;
      rf_addr_d = rf_addr_q;
      rf_data_d = rf_data_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= GRANT_LD;
      err_q        <= 1'b0;
      rf_we_q      <= 1'b0;
      rf_addr_q    <= ZERO_ADDR;
      rf_data_q    <= {DATA_WIDTH{1'b0}};
      for (int i = 0; i < NUM_REGS; i++) begin
        count_q[i] <= 2'd0;
      end
    end else begin
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
      rf_we_q      <= rf_we_d;
      rf_addr_q    <= rf_addr_d;
      rf_data_q    <= rf_data_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        count_q[i] <= count_d[i];
      end
    end
  end

  assign rf_we         = rf_we_q;
  assign rf_rd_addr    = rf_addr_q;
  assign rf_rd_data    = rf_data_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_wb_scheduler.sv
// Scoreboard bench for wb_scheduler: a reference model predicts grants, scoreboard
// state and the registered write port; a monitor checks the write port each cycle.
module tb_wb_scheduler;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ex_valid, ld_valid, iss_valid, flush;
  logic [AW-1:0] ex_rd, ld_rd, iss_rd, rs1_addr, rs2_addr;
  logic [DW-1:0] ex_data, ld_data;
  logic          ex_ready, ld_ready, iss_ready, rs1_busy, rs2_busy, err_underflow;
  logic          rf_we;
  logic [AW-1:0] rf_rd_addr;
  logic [DW-1:0] rf_rd_data;

  wb_scheduler #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_data(ex_data), .ex_ready(ex_ready),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .rf_we(rf_we), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .flush(flush), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  int  checks = 0;
  int  errors = 0;
  int  cnt [32];
  bit  last_ld;
  bit  m_err;
  bit  ex_gnt, ld_gnt;
  bit  mon_en = 1'b0;
  wr_t exp_q[$];
  wr_t mon_e;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: each cycle the write port must match the oldest predicted write.
  always @(negedge clk) begin
    if (mon_en && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("rf_we", {63'd0, rf_we}, {63'd0, mon_e.we});
      if (mon_e.we) begin
        chk("rf_rd_addr", {59'd0, rf_rd_addr}, {59'd0, mon_e.addr});
        chk("rf_rd_data", {32'd0, rf_rd_data}, {32'd0, mon_e.data});
      end
    end
  end

  task automatic drv(bit ev, int er, logic [DW-1:0] ed, bit lv, int lr, logic [DW-1:0] ldd,
                     bit iv, int ir, bit fl);
    ex_valid = ev;  ex_rd = AW'(er);  ex_data = ed;
    ld_valid = lv;  ld_rd = AW'(lr);  ld_data = ldd;
    iss_valid = iv; iss_rd = AW'(ir); flush = fl;
  endtask

  // One clock of model evaluation: check combinational outputs, predict, advance.
  task automatic cycle();
    bit            iss_ok, inc, dec;
    logic [AW-1:0] rd;
    wr_t           e;
    #1;
    ex_gnt = ex_valid && (!ld_valid || last_ld);
    ld_gnt = ld_valid && !ex_gnt;
    iss_ok = (iss_rd == 0) || (cnt[iss_rd] < 3);
    chk("ex_ready", {63'd0, ex_ready}, {63'd0, ex_gnt});
    chk("ld_ready", {63'd0, ld_ready}, {63'd0, ld_gnt});
    chk("iss_ready", {63'd0, iss_ready}, {63'd0, iss_ok});
    chk("rs1_busy", {63'd0, rs1_busy}, {63'd0, (rs1_addr != 0) && (cnt[rs1_addr] != 0)});
    chk("rs2_busy", {63'd0, rs2_busy}, {63'd0, (rs2_addr != 0) && (cnt[rs2_addr] != 0)});
    chk("err_underflow", {63'd0, err_underflow}, {63'd0, m_err});
    e.we = 1'b0; e.addr = '0; e.data = '0;
    rd = ex_gnt ? ex_rd : ld_rd;
    if (ex_gnt || ld_gnt) begin
      last_ld = ld_gnt;
      e.we    = (rd != 0);
      e.addr  = rd;
      e.data  = ex_gnt ? ex_data : ld_data;
    end
    exp_q.push_back(e);
    inc = iss_valid && iss_ok && (iss_rd != 0);
    dec = (ex_gnt || ld_gnt) && (rd != 0);
    if (flush) begin
      foreach (cnt[i]) cnt[i] = 0;
    end else if (!(inc && dec && (iss_rd == rd))) begin
      if (inc) cnt[iss_rd]++;
      if (dec) begin
        if (cnt[rd] == 0) m_err = 1'b1;
        else cnt[rd]--;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst_n  = 1'b0;
    exp_q.delete();
    foreach (cnt[i]) cnt[i] = 0;
    last_ld = 1'b1;
    m_err   = 1'b0;
    ex_gnt  = 1'b0;
    ld_gnt  = 1'b0;
    drv(1, 3, 32'h1234_5678, 1, 4, 32'h8765_4321, 1, 3, 0);
    #1;
    chk("rst_rf_we", {63'd0, rf_we}, 64'd0);
    chk("rst_rf_addr", {59'd0, rf_rd_addr}, 64'd0);
    chk("rst_rf_data", {32'd0, rf_rd_data}, 64'd0);
    chk("rst_ex_ready", {63'd0, ex_ready}, 64'd0);
    chk("rst_ld_ready", {63'd0, ld_ready}, 64'd0);
    chk("rst_iss_ready", {63'd0, iss_ready}, 64'd1);
    chk("rst_rs1_busy", {63'd0, rs1_busy}, 64'd0);
    chk("rst_rs2_busy", {63'd0, rs2_busy}, 64'd0);
    chk("rst_err", {63'd0, err_underflow}, 64'd0);
    drv(0, 0, 32'd0, 0, 0, 32'd0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  initial begin
    rs1_addr = '0;
    rs2_addr = '0;
    rst_n    = 1'b0;
    do_reset();

    // Single write with busy before/after.
    rs1_addr = 5'd5;
    drv(0, 0, 32'd0, 0, 0, 32'd0, 1, 5, 0); cycle();
    drv(1, 5, 32'hDEADBEEF, 0, 0, 32'd0, 0, 0, 0);
    #1 chk("single_busy_before", {63'd0, rs1_busy}, 64'd1);
    cycle();
    drv(0, 0, 32'd0, 0, 0, 32'd0, 0, 0, 0); cycle();
    chk("single_busy_after", {63'd0, rs1_busy}, 64'd0);

    // Contention from reset: EX, LD, EX, LD.
    do_reset();
    drv(1, 1, 32'h1111_0000, 1, 2, 32'h2222_0000, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      #1 chk("contention_ex_grant", {63'd0, ex_ready}, (i % 2 == 0) ? 64'd1 : 64'd0);
      cycle();
      if (ex_gnt) begin ex_rd = ex_rd + 5'd2; ex_data = ex_data + 32'd1; end
      if (ld_gnt) begin ld_rd = ld_rd + 5'd2; ld_data = ld_data + 32'd1; end
    end
    drv(0, 0, 32'd0, 0, 0, 32'd0, 0, 0, 0); cycle();

    // Saturation on r7.
    do_reset();
    rs1_addr = 5'd7;
    repeat (3) begin drv(0, 0, 32'd0, 0, 0, 32'd0, 1, 7, 0); cycle(); end
    #1 chk("sat_stall", {63'd0, iss_ready}, 64'd0);
    drv(0, 0, 32'd0, 1, 7, 32'h0000_0077, 1, 7, 0); cycle();
    drv(0, 0, 32'd0, 0, 0, 32'd0, 0, 7, 0);
    #1 chk("sat_release", {63'd0, iss_ready}, 64'd1);
    for (int i = 0; i < 2; i++) begin
      drv(0, 0, 32'd0, 1, 7, 32'h0000_0070 + 32'(i), 0, 7, 0); cycle();
    end
    drv(0, 0, 32'd0, 0, 0, 32'd0, 0, 0, 0); cycle();
    chk("sat_busy_cleared", {63'd0, rs1_busy}, 64'd0);

    // Same-cycle issue and writeback on r9.
    do_reset();
    rs2_addr = 5'd9;
    drv(0, 0, 32'd0, 0, 0, 32'd0, 1, 9, 0); cycle();
    drv(1, 9, 32'h0909_0909, 0, 0, 32'd0, 1, 9, 0); cycle();
    drv(0, 0, 32'd0, 0, 0, 32'd0, 0, 0, 0); cycle();
    chk("simul_busy", {63'd0, rs2_busy}, 64'd1);
    chk("simul_err", {63'd0, err_underflow}, 64'd0);

    // Flush then underflow on r3.
    do_reset();
    rs1_addr = 5'd3; rs2_addr = 5'd11;
    drv(0, 0, 32'd0, 0, 0, 32'd0, 1, 3, 0); cycle();
    drv(0, 0, 32'd0, 0, 0, 32'd0, 1, 11, 0); cycle();
    drv(0, 0, 32'd0, 0, 0, 32'd0, 1, 3, 1); cycle();
    drv(0, 0, 32'd0, 1, 3, 32'h0303_0303, 0, 0, 0); cycle();
    drv(0, 0, 32'd0, 0, 0, 32'd0, 0, 0, 0);
    repeat (3) cycle();
    chk("flush_err_sticky", {63'd0, err_underflow}, 64'd1);

    // Reset in the cycle after a transfer.
    do_reset();
    rs1_addr = 5'd4;
    repeat (2) begin drv(0, 0, 32'd0, 0, 0, 32'd0, 1, 4, 0); cycle(); end
    drv(1, 4, 32'h0000_CAFE, 0, 0, 32'd0, 0, 0, 0); cycle();
    #2 chk("midop_busy_before", {63'd0, rs1_busy}, 64'd1);
    do_reset();
    drv(0, 0, 32'd0, 0, 0, 32'd0, 0, 0, 0);
    repeat (3) cycle();

    // Randomized traffic on a small register window to force hazards.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (!ex_valid || ex_gnt) begin
        ex_valid = 1'($urandom_range(0, 1));
        ex_rd    = AW'($urandom_range(0, 7));
        ex_data  = $urandom;
      end
      if (!ld_valid || ld_gnt) begin
        ld_valid = 1'($urandom_range(0, 1));
        ld_rd    = AW'($urandom_range(0, 7));
        ld_data  = $urandom;
      end
      iss_valid = 1'($urandom_range(0, 1));
      iss_rd    = AW'($urandom_range(0, 7));
      rs1_addr  = AW'($urandom_range(0, 7));
      rs2_addr  = AW'($urandom_range(0, 7));
      flush     = ($urandom_range(0, 24) == 0);
      cycle();
    end
    drv(0, 0, 32'd0, 0, 0, 32'd0, 0, 0, 0);
    repeat (2) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
